pos_tracker: RTL and testbench
==============================

Name: pos_tracker

Overview:
- Upstream producer for the read-only I2C slave: generates the x_pos, y_pos and status bytes that the slave serves on a read.
- Decodes two quadrature encoders (X and Y axes) into 8-bit positions and debounces an active-low button.
- Keeps sticky event flags.
- Presents a freeze-able snapshot, so that all three bytes stay mutually coherent for the whole of an I2C read.

Parameters:
- POS_INIT, 8'd128: reset value of both position counters.
- DIV_SHIFT, 2: valid quadrature transitions per position count = 2**DIV_SHIFT. Legal range 0..2.
- SATURATE, 1: 1 = clamp positions at 0 and 255; 0 = wrap modulo 256.
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable clk cycles required before the debounced button changes.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- enc_x_a, input, 1: X encoder phase A (asynchronous).
- enc_x_b, input, 1: X encoder phase B (asynchronous).
- enc_y_a, input, 1: Y encoder phase A (asynchronous).
- enc_y_b, input, 1: Y encoder phase B (asynchronous).
- btn_n, input, 1: button, active-low (asynchronous).
- freeze, input, 1: level, high for the duration of an I2C transaction; holds the outputs.
- clr_flags, input, 1: one-cycle pulse that clears the sticky status bits (issued after the status byte has been read).
- x_pos, output, 8: X position snapshot.
- y_pos, output, 8: Y position snapshot.
- status, output, 8: status snapshot.

Behaviour:
- Reset is asynchronous on rst_n low. Reset values:
  - Internal positions = POS_INIT.
  - Sub-counters = 0.
  - Sticky flags = 0.
  - Debounced button = 0 (released).
  - All sync flops = 0.
  - Outputs: x_pos = y_pos = POS_INIT, status = 8'h80.
- Synchronisation: every asynchronous input passes through a 2-FF synchroniser. Decode operates on the second-stage value and its one-cycle-delayed copy.
- Quadrature decode, per axis, prev AB -> cur AB:
  - Forward (+1): 00->01, 01->11, 11->10, 10->00.
  - Reverse (-1): the reverse of each of those.
  - No change: no action.
  - Both bits changed: illegal; set the err sticky flag for that axis, no count.
- Sub-counter (DIV_SHIFT bits):
  - Each valid step increments or decrements the sub-counter.
  - The position changes only when the sub-counter wraps: up-wrap = +1, down-wrap = -1.
  - With DIV_SHIFT = 0, every valid step changes the position.
- Position update:
  - SATURATE = 1: an increment at 255 or a decrement at 0 leaves the value unchanged and sets the sat sticky flag for that axis.
  - SATURATE = 0: wrap modulo 256 without setting sat.
  - Any position change sets the moved sticky flag for that axis.
- Button debounce:
  - Counter resets whenever the synced btn_n equals the current debounced state.
  - The debounced state toggles when the counter reaches DEBOUNCE_CYCLES-1 while the input still differs.
  - pressed = debounced active.
- Status bit map:
  - [0] button pressed, live level.
  - [1] x_moved, [2] y_moved.
  - [3] x_err, [4] y_err.
  - [5] x_sat, [6] y_sat.
  - [7] constant 1 (alive marker).
- Sticky flags: cleared by clr_flags. When a set event and clr_flags occur in the same cycle, set wins.
- Output register:
  - When freeze = 0, outputs load from internal state every clk.
  - When freeze = 1, outputs hold; internal decode, counting and flag setting continue.
  - On freeze falling, outputs reflect the accumulated state on the next clk.
- Latency:
  - Encoder edge to internal position: 3 clk (2 sync + 1 update).
  - Edge to output when unfrozen: 4 clk.
  - Button: 2 sync + DEBOUNCE_CYCLES + 1 output.
- Simultaneous events: X and Y are fully independent, so same-cycle steps on both axes both count.
- Reset mid-operation: everything returns to reset values immediately. The first post-reset sample is compared against prev = 00, so a non-zero AB at reset release yields one decode event; an AB of 11 yields err. This is accepted and documented.

Decomposition:
- Package pos_tracker_pkg:
  - STATUS_* bit index constants.
  - quad_step_t enum {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL}.
  - The decode function (prev AB, cur AB) -> quad_step_t.
- Sub-module quad_axis, instantiated twice. It contains:
  - Synchroniser, decode, sub-counter and saturating position.
  - Outputs: pos[7:0], moved_evt, err_evt, sat_evt (1-clk pulses).
- The top level holds the debouncer, sticky flags and output snapshot register.

Test Plan:
- Reset release, no encoder activity -> x_pos = y_pos = 128, status = 8'h80.
- DIV_SHIFT = 2: 8 forward X transitions (00,01,11,10 x2) -> x_pos = 130, status[1] = 1, y_pos = 128; first change on output 4 clk after the 4th edge.
- SATURATE = 1: 200 reverse Y detents -> y_pos = 0, status[6] = 1; one more forward detent -> y_pos = 1.
- X AB jump 00->11 -> status[3] = 1, x_pos unchanged; clr_flags pulse -> status[3] = 0 unless a new illegal step occurs in that same cycle (then it stays 1).
- freeze = 1, then 4 forward X detents -> x_pos holds its old value throughout; freeze = 0 -> x_pos = old + 4 on the next clk.
- DEBOUNCE_CYCLES = 10: btn_n low-glitch for 5 cycles -> status[0] stays 0; held low for 12 cycles -> status[0] = 1 at 2 + 10 + 1 clk after the edge.

Source files
------------

// File: rtl/pos_tracker_pkg.sv
// Shared types, status bit positions and the quadrature step decoder for the
// position tracker that feeds the read-only I2C slave.
package pos_tracker_pkg;

    localparam int STATUS_BTN     = 0;
    localparam int STATUS_X_MOVED = 1;
    localparam int STATUS_Y_MOVED = 2;
    localparam int STATUS_X_ERR   = 3;
    localparam int STATUS_Y_ERR   = 4;
    localparam int STATUS_X_SAT   = 5;
    localparam int STATUS_Y_SAT   = 6;
    localparam int STATUS_ALIVE   = 7;

    localparam logic [7:0] STICKY_MASK  = 8'h7E;
    localparam logic [7:0] STATUS_RESET = 8'h80;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILLEGAL
    } quad_step_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; any two-bit jump is illegal.
    function automatic quad_step_t quad_decode(input logic [1:0] prev_ab,
                                               input logic [1:0] cur_ab);
        logic [1:0] fwd_next;
        quad_step_t step;
        case (prev_ab)
            2'b00:   fwd_next = 2'b01;
            2'b01:   fwd_next = 2'b11;
            2'b11:   fwd_next = 2'b10;
            default: fwd_next = 2'b00;
        endcase
        if (cur_ab == prev_ab) begin
            step = STEP_NONE;
        end else if ((cur_ab ^ prev_ab) == 2'b11) begin
            step = STEP_ILLEGAL;
        end else if (cur_ab == fwd_next) begin
            step = STEP_FWD;
        end else begin
            step = STEP_REV;
        end
        return step;
    endfunction

endpackage

// File: rtl/pos_tracker_quad_axis.sv
// One encoder axis: 2-FF synchroniser, quadrature decode, detent sub-counter
// and an 8-bit position that either saturates or wraps.
module quad_axis
    import pos_tracker_pkg::*;
#(
    parameter logic [7:0] POS_INIT  = 8'd128,
    parameter int         DIV_SHIFT = 2,
    parameter bit         SATURATE  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_a,
    input  logic       i_b,
    output logic [7:0] o_pos,
    output logic       o_moved_evt,
    output logic       o_err_evt,
    output logic       o_sat_evt
);

    // A zero-width sub-counter is modelled as one bit pinned at zero, so every
    // valid step wraps and moves the position.
    localparam int               SUB_W   = (DIV_SHIFT == 0) ? 1 : DIV_SHIFT;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'((1 << DIV_SHIFT) - 1);

    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_prev;
    logic [SUB_W-1:0] r_sub;
    logic [7:0]       r_pos;

    quad_step_t w_step;
    logic       w_up;
    logic       w_down;
    logic       w_blocked;
    logic       w_moved;
    logic [7:0] w_next_pos;

    always_comb begin
        w_step     = quad_decode(r_prev, r_sync2);
        w_up       = (w_step == STEP_FWD) && (r_sub == SUB_MAX);
        w_down     = (w_step == STEP_REV) && (r_sub == '0);
        w_blocked  = SATURATE && ((w_up && (r_pos == 8'hFF)) ||
                                  (w_down && (r_pos == 8'h00)));
        w_moved    = (w_up || w_down) && !w_blocked;
        w_next_pos = r_pos;
        if (w_moved) begin
            w_next_pos = w_up ? (r_pos + 8'd1) : (r_pos - 8'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_prev  <= 2'b00;
            r_sub   <= '0;
            r_pos   <= POS_INIT;
        end else begin
            r_sync1 <= {i_a, i_b};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pos   <= w_next_pos;
            if (w_step == STEP_FWD) begin
                r_sub <= (r_sub == SUB_MAX) ? '0 : (r_sub + 1'b1);
            end else if (w_step == STEP_REV) begin
                r_sub <= (r_sub == '0) ? SUB_MAX : (r_sub - 1'b1);
            end
        end
    end

    assign o_pos       = r_pos;
    assign o_moved_evt = w_moved;
    assign o_err_evt   = (w_step == STEP_ILLEGAL);
    assign o_sat_evt   = w_blocked;

endmodule

// File: rtl/pos_tracker.sv
// Position tracker top: two encoder axes, button debouncer, sticky event flags
// and a freezable output snapshot that keeps the three bytes coherent.
module pos_tracker
    import pos_tracker_pkg::*;
#(
    parameter logic [7:0]  POS_INIT        = 8'd128,
    parameter int          DIV_SHIFT       = 2,
    parameter bit          SATURATE        = 1'b1,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_x_a,
    input  logic       enc_x_b,
    input  logic       enc_y_a,
    input  logic       enc_y_b,
    input  logic       btn_n,
    input  logic       freeze,
    input  logic       clr_flags,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic [7:0] status
);

    localparam logic [15:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic [7:0] w_x_pos;
    logic [7:0] w_y_pos;
    logic       w_x_moved;
    logic       w_x_err;
    logic       w_x_sat;
    logic       w_y_moved;
    logic       w_y_err;
    logic       w_y_sat;

    quad_axis #(
        .POS_INIT (POS_INIT),
        .DIV_SHIFT(DIV_SHIFT),
        .SATURATE (SATURATE)
    ) u_axis_x (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_a        (enc_x_a),
        .i_b        (enc_x_b),
        .o_pos      (w_x_pos),
        .o_moved_evt(w_x_moved),
        .o_err_evt  (w_x_err),
        .o_sat_evt  (w_x_sat)
    );

    quad_axis #(
        .POS_INIT (POS_INIT),
        .DIV_SHIFT(DIV_SHIFT),
        .SATURATE (SATURATE)
    ) u_axis_y (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_a        (enc_y_a),
        .i_b        (enc_y_b),
        .o_pos      (w_y_pos),
        .o_moved_evt(w_y_moved),
        .o_err_evt  (w_y_err),
        .o_sat_evt  (w_y_sat)
    );

    logic        r_btn_sync1;
    logic        r_btn_sync2;
    logic [15:0] r_db_cnt;
    logic        r_pressed;
    logic        w_btn_active;

    // Debounced state is kept active-high (1 = pressed) against the inverted input.
    assign w_btn_active = ~r_btn_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_sync1 <= 1'b0;
            r_btn_sync2 <= 1'b0;
            r_db_cnt    <= 16'd0;
            r_pressed   <= 1'b0;
        end else begin
            r_btn_sync1 <= btn_n;
            r_btn_sync2 <= r_btn_sync1;
            if (w_btn_active == r_pressed) begin
                r_db_cnt <= 16'd0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt  <= 16'd0;
                r_pressed <= ~r_pressed;
            end else begin
                r_db_cnt <= r_db_cnt + 16'd1;
            end
        end
    end

    logic [7:0] r_sticky;
    logic [7:0] w_set;
    logic [7:0] w_status;

    always_comb begin
        w_set                 = 8'h00;
        w_set[STATUS_X_MOVED] = w_x_moved;
        w_set[STATUS_Y_MOVED] = w_y_moved;
        w_set[STATUS_X_ERR]   = w_x_err;
        w_set[STATUS_Y_ERR]   = w_y_err;
        w_set[STATUS_X_SAT]   = w_x_sat;
        w_set[STATUS_Y_SAT]   = w_y_sat;

        w_status               = r_sticky;
        w_status[STATUS_BTN]   = r_pressed;
        w_status[STATUS_ALIVE] = 1'b1;
    end

    // A new event in the same cycle as a clear survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 8'h00;
        end else begin
            r_sticky <= ((clr_flags ? 8'h00 : r_sticky) | w_set) & STICKY_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos  <= POS_INIT;
            y_pos  <= POS_INIT;
            status <= STATUS_RESET;
        end else if (!freeze) begin
            x_pos  <= w_x_pos;
            y_pos  <= w_y_pos;
            status <= w_status;
        end
    end

endmodule

// File: tb/tb_pos_tracker.sv
// Directed bench for pos_tracker: a step-count model predicts every output byte
// each cycle, and literal checkpoints pin the model to hand-computed values.
module tb_pos_tracker;

    localparam int DB_CYCLES = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] xAb = 2'b00;
    logic [1:0] yAb = 2'b00;
    logic       btnN = 1'b1;
    logic       frz = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] xPos;
    logic [7:0] yPos;
    logic [7:0] status;

    int vectors = 0;
    int miscompares = 0;

    pos_tracker #(
        .POS_INIT       (8'd128),
        .DIV_SHIFT      (2),
        .SATURATE       (1'b1),
        .DEBOUNCE_CYCLES(16'd10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enc_x_a  (xAb[1]),
        .enc_x_b  (xAb[0]),
        .enc_y_a  (yAb[1]),
        .enc_y_b  (yAb[0]),
        .btn_n    (btnN),
        .freeze   (frz),
        .clr_flags(clr),
        .x_pos    (xPos),
        .y_pos    (yPos),
        .status   (status)
    );

    always #5 clk = ~clk;

    // Model state: total signed step count per axis; position moves when the
    // detent index floor(steps/4) changes.
    int         mStepsX, mStepsY, mPosX, mPosY, mRun;
    bit         mPressed;
    logic [5:0] mFlags;
    logic [1:0] xHist [3];
    logic [1:0] yHist [3];
    logic       bHist [3];
    logic [7:0] expX, expY, expStatus;
    bit         mx, ex, sx, my, ey, sy;

    function automatic int grayIndex(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] grayCode(input int idx);
        case (idx % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic axisModel(input logic [1:0] prev, input logic [1:0] cur,
                             inout int steps, inout int pos,
                             output bit moved, output bit err, output bit sat);
        int d, dir, delta, target;
        moved = 0; err = 0; sat = 0;
        d = (grayIndex(cur) - grayIndex(prev) + 4) % 4;
        if (d == 2) begin
            err = 1;
        end else if (d != 0) begin
            dir = (d == 1) ? 1 : -1;
            delta = ((steps + dir) >>> 2) - (steps >>> 2);
            steps = steps + dir;
            if (delta != 0) begin
                target = pos + delta;
                if (target < 0 || target > 255) sat = 1;
                else begin
                    pos = target;
                    moved = 1;
                end
            end
        end
    endtask

    task automatic modelReset();
        mStepsX = 0; mStepsY = 0; mPosX = 128; mPosY = 128;
        mRun = 0; mPressed = 0; mFlags = '0;
        for (int i = 0; i < 3; i++) begin
            xHist[i] = 2'b00; yHist[i] = 2'b00; bHist[i] = 1'b0;
        end
        expX = 8'd128; expY = 8'd128; expStatus = 8'h80;
    endtask

    task automatic modelStep();
        logic sample;
        if (!frz) begin
            expX = mPosX[7:0];
            expY = mPosY[7:0];
            expStatus = {1'b1, mFlags, mPressed};
        end
        axisModel(xHist[2], xHist[1], mStepsX, mPosX, mx, ex, sx);
        axisModel(yHist[2], yHist[1], mStepsY, mPosY, my, ey, sy);
        if (clr) mFlags = '0;
        mFlags = mFlags | {sy, sx, ey, ex, my, mx};
        sample = ~bHist[1];
        if (sample != mPressed) begin
            mRun++;
            if (mRun == DB_CYCLES) begin
                mPressed = ~mPressed;
                mRun = 0;
            end
        end else begin
            mRun = 0;
        end
        xHist[2] = xHist[1]; xHist[1] = xHist[0]; xHist[0] = xAb;
        yHist[2] = yHist[1]; yHist[1] = yHist[0]; yHist[0] = yAb;
        bHist[2] = bHist[1]; bHist[1] = bHist[0]; bHist[0] = btnN;
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    task automatic compareByte(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%02h, expected 0x%02h", name, $time, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                compareByte("model_x_pos", xPos, expX);
                compareByte("model_y_pos", yPos, expY);
                compareByte("model_status", status, expStatus);
            end
        end
    end

    task automatic checkOutput(input string name, input int x, input int y, input logic [7:0] st);
        compareByte({name, "_x"}, xPos, x[7:0]);
        compareByte({name, "_y"}, yPos, y[7:0]);
        compareByte({name, "_status"}, status, st);
    endtask

    task automatic applyStimulus(input logic [1:0] x, input logic [1:0] y,
                                 input logic b, input logic f, input int cycles);
        xAb = x; yAb = y; btnN = b; frz = f;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulseClr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // One full detent per axis: dir +1 forward, -1 reverse, 0 hold.
    task automatic moveAxes(input int xDir, input int yDir, input int hold);
        logic [1:0] nx, ny;
        for (int i = 1; i <= 4; i++) begin
            nx = xAb; ny = yAb;
            if (xDir > 0) nx = grayCode(i);
            else if (xDir < 0) nx = grayCode(4 - i);
            if (yDir > 0) ny = grayCode(i);
            else if (yDir < 0) ny = grayCode(4 - i);
            applyStimulus(nx, ny, btnN, frz, hold);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset", 128, 128, 8'h80);

        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0, 2);
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 2);
        applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 2);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 3);
        checkOutput("latency_before", 128, 128, 8'h80);
        @(negedge clk);
        checkOutput("latency_after", 129, 128, 8'h82);

        moveAxes(1, 0, 2);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 5);
        checkOutput("fwd8", 130, 128, 8'h82);

        pulseClr();
        repeat (2) @(negedge clk);
        checkOutput("clear", 130, 128, 8'h80);

        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 6);
        checkOutput("illegal", 130, 128, 8'h88);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 6);
        pulseClr();
        repeat (2) @(negedge clk);
        checkOutput("err_cleared", 130, 128, 8'h80);

        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 2);
        pulseClr();
        repeat (5) @(negedge clk);
        checkOutput("set_beats_clr", 130, 128, 8'h88);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 6);
        pulseClr();
        repeat (2) @(negedge clk);

        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 2);
        repeat (2) moveAxes(1, 0, 2);
        checkOutput("frozen_mid", 130, 128, 8'h80);
        repeat (2) moveAxes(1, 0, 2);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 5);
        checkOutput("frozen_end", 130, 128, 8'h80);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 1);
        checkOutput("thaw", 134, 128, 8'h82);

        pulseClr();
        moveAxes(1, 1, 2);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 5);
        checkOutput("both_axes", 135, 129, 8'h86);

        pulseClr();
        repeat (200) moveAxes(0, -1, 1);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 5);
        checkOutput("y_saturate", 135, 0, 8'hC4);
        pulseClr();
        moveAxes(0, 1, 2);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 5);
        checkOutput("y_recover", 135, 1, 8'h84);

        pulseClr();
        repeat (2) @(negedge clk);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 5);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 20);
        checkOutput("glitch", 135, 1, 8'h80);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 12);
        checkOutput("btn_early", 135, 1, 8'h80);
        @(negedge clk);
        checkOutput("btn_pressed", 135, 1, 8'h81);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 5);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 20);
        checkOutput("btn_released", 135, 1, 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
